adder_mp_seq: RTL and testbench

//  Multi-precision add/sub sequencer. Reuses one full_adder_32bit over NWORDS cycles,
//  LS word first, chaining carry through a register. Handles operands of NWORDS*32 bits.

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_mp_seq_if.sv | 31 +++
 rtl/full_adder_32bit.sv | 12 +
 rtl/adder_mp_seq.sv | 134 +++++++++++++
 tb/tb_adder_mp_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the multi-precision add/sub sequencer.
package adder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  // The word counter must be at least one bit wide even for single-word operands.
  function automatic int cnt_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/adder_mp_seq_if.sv
// Command/result handshake bundle between a command source, the sequencer and a result sink.
interface adder_mp_seq_if #(
  parameter int NWORDS = 4
);
  import adder_pkg::*;

  localparam int W = WORD_W;

  logic                in_valid;
  logic                in_ready;
  logic                in_sub;
  logic                in_cin;
  logic [NWORDS*W-1:0] in_a;
  logic [NWORDS*W-1:0] in_b;
  logic                out_valid;
  logic                out_ready;
  logic [NWORDS*W-1:0] out_sum;
  logic                out_cout;
  logic                out_ovf;

  modport master (
    output in_valid, in_sub, in_cin, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_sub, in_cin, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/full_adder_32bit.sv
// Combinational 32-bit adder with carry-in and carry-out; one word slice of the sequencer.
module full_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/adder_mp_seq.sv
// Multi-precision add/sub: one 32-bit adder reused over NWORDS cycles, LS word first,
// with the inter-word carry held in a register.
module adder_mp_seq
  import adder_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_mp_seq_if.slave  bus
);

  localparam int              W    = WORD_W;
  localparam int              CW   = cnt_width(NWORDS);
  localparam logic [CW-1:0]   LAST = CW'(NWORDS - 1);

  seq_state_t                  state_reg;
  seq_state_t                  state_next;
  logic [CW-1:0]               cnt_reg;
  logic                        carry_reg;
  logic [NWORDS-1:0][W-1:0]    a_reg;
  logic [NWORDS-1:0][W-1:0]    b_reg;
  logic                        cout_reg;
  logic                        ovf_reg;
  logic [NWORDS*W-1:0]         sum_flat;

  logic                        ready;
  logic                        accept;
  logic                        last_word;
  logic [W-1:0]                a_word;
  logic [W-1:0]                b_word;
  logic [W-1:0]                add_sum;
  logic                        add_cout;

  assign last_word = (cnt_reg == LAST);
  assign accept    = bus.in_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_word) state_next = DONE;
      end
      DONE: begin
        // Consuming the result frees the datapath, so a waiting command is taken on the same edge.
        ready = bus.out_ready;
        if (bus.out_ready) state_next = bus.in_valid ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (cnt_reg == CW'(i)) begin
        a_word = a_reg[i];
        b_word = b_reg[i];
      end
    end
  end

  full_adder_32bit u_fa (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: B is stored inverted and the initial carry forced high.
      a_reg     <= bus.in_a;
      b_reg     <= bus.in_sub ? ~bus.in_b : bus.in_b;
      carry_reg <= bus.in_sub | bus.in_cin;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      carry_reg <= add_cout;
      if (last_word) begin
        cout_reg <= add_cout;
        ovf_reg  <= (a_word[W-1] == b_word[W-1]) && (add_sum[W-1] != a_word[W-1]);
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Each result word only changes in its own RUN slot, so unwritten words keep the previous result.
  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
      logic [W-1:0] word_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (state_reg == RUN && cnt_reg == CW'(gi)) begin
          word_reg <= add_sum;
        end
      end

      assign sum_flat[gi*W +: W] = word_reg;
    end
  endgenerate

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_sum   = sum_flat;
  assign bus.out_cout  = cout_reg;
  assign bus.out_ovf   = ovf_reg;

endmodule

// File: tb/tb_adder_mp_seq.sv
// Directed bench for adder_mp_seq (NWORDS=4 and NWORDS=1) with a full-width arithmetic reference.
module tb_adder_mp_seq;
  import adder_pkg::*;

  localparam int NW = 4;

  typedef struct packed {
    logic [127:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t q4[$];
  res_t q1[$];
  logic [127:0] all_f = '1;

  always #5 clk = ~clk;

  adder_mp_seq_if #(.NWORDS(NW)) bus4 ();
  adder_mp_seq_if #(.NWORDS(1))  bus1 ();

  adder_mp_seq #(.NWORDS(NW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  adder_mp_seq #(.NWORDS(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: nb-bit two's-complement add of A and (B or ~B) with the appropriate carry-in.
  function automatic res_t model(input logic [127:0] a, input logic [127:0] b,
                                 input logic sub, input logic cin, input int nb);
    logic [127:0] mask;
    logic [127:0] bb;
    logic [127:0] aa;
    logic [128:0] full;
    res_t         r;
    mask   = (nb == 128) ? '1 : ((128'd1 << nb) - 128'd1);
    aa     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + 129'(sub ? 1'b1 : cin);
    r.sum  = full[127:0] & mask;
    r.cout = full[nb];
    r.ovf  = (aa[nb-1] == bb[nb-1]) && (r.sum[nb-1] != aa[nb-1]);
    return r;
  endfunction

  // Scoreboards: an accept pushes the reference result, every valid cycle is compared, consume pops.
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
    end else begin
      if (bus4.out_valid) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon4_spurious_valid: out_valid=1, expected 0");
        end else begin
          chk("mon4_sum", bus4.out_sum, q4[0].sum);
          chk("mon4_cout", bus4.out_cout, q4[0].cout);
          chk("mon4_ovf", bus4.out_ovf, q4[0].ovf);
          if (bus4.out_ready) void'(q4.pop_front());
        end
      end
      if (bus4.in_valid && bus4.in_ready)
        q4.push_back(model(bus4.in_a, bus4.in_b, bus4.in_sub, bus4.in_cin, 128));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
    end else begin
      if (bus1.out_valid) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon1_spurious_valid: out_valid=1, expected 0");
        end else begin
          chk("mon1_sum", bus1.out_sum, q1[0].sum);
          chk("mon1_cout", bus1.out_cout, q1[0].cout);
          chk("mon1_ovf", bus1.out_ovf, q1[0].ovf);
          if (bus1.out_ready) void'(q1.pop_front());
        end
      end
      if (bus1.in_valid && bus1.in_ready)
        q1.push_back(model({96'd0, bus1.in_a}, {96'd0, bus1.in_b}, bus1.in_sub, bus1.in_cin, 32));
    end
  end

  task automatic op4(input logic [127:0] a, input logic [127:0] b, input logic sub, input logic cin,
                     input logic [127:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                     input string nm);
    int n;
    @(posedge clk); #1;
    bus4.in_a = a; bus4.in_b = b; bus4.in_sub = sub; bus4.in_cin = cin;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    n = 0;
    while (!bus4.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    n = 0;
    while (!bus4.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n, NW);
    chk({nm, "_sum"}, bus4.out_sum, exp_sum);
    chk({nm, "_cout"}, bus4.out_cout, exp_cout);
    chk({nm, "_ovf"}, bus4.out_ovf, exp_ovf);
    $display("op4 %s: a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d", nm, a, b, sub, cin,
             bus4.out_sum, bus4.out_cout, bus4.out_ovf);
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    chk({nm, "_consumed"}, bus4.out_valid, 0);
  endtask

  task automatic op1(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                     input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                     input string nm);
    int n;
    @(posedge clk); #1;
    bus1.in_a = a; bus1.in_b = b; bus1.in_sub = sub; bus1.in_cin = cin;
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
    n = 0;
    while (!bus1.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n, 1);
    chk({nm, "_sum"}, bus1.out_sum, exp_sum);
    chk({nm, "_cout"}, bus1.out_cout, exp_cout);
    chk({nm, "_ovf"}, bus1.out_ovf, exp_ovf);
    $display("op1 %s: a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d", nm, a, b, sub,
             bus1.out_sum, bus1.out_cout, bus1.out_ovf);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    int n;
    bus4.in_valid = 0; bus4.in_sub = 0; bus4.in_cin = 0; bus4.in_a = '0; bus4.in_b = '0; bus4.out_ready = 0;
    bus1.in_valid = 0; bus1.in_sub = 0; bus1.in_cin = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_in_ready", bus4.in_ready, 1);
    chk("rst_out_valid", bus4.out_valid, 0);
    chk("rst_out_sum", bus4.out_sum, 0);
    chk("rst_out_cout", bus4.out_cout, 0);
    chk("rst_out_ovf", bus4.out_ovf, 0);
    chk("rst1_in_ready", bus1.in_ready, 1);
    chk("rst1_out_valid", bus1.out_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    op4(128'hFFFF_FFFF, 128'd1, 0, 0, 128'h1_0000_0000, 0, 0, "t1_word_carry");
    op4(all_f, 128'd1, 0, 0, 128'd0, 1, 0, "t2_full_ripple");
    op4(128'd5, 128'd7, 1, 0, {{96{1'b1}}, 32'hFFFF_FFFE}, 0, 0, "t3_sub_borrow");
    op4(128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1, 0,
        128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 1, "t3_sub_ovf");
    op4(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd0, 0, 1,
        128'h8000_0000_0000_0000_0000_0000_0000_0000, 0, 1, "tx_add_cin_ovf");
    op4(128'd7, 128'd5, 1, 1, 128'd2, 1, 0, "tx_sub_cin_ignored");

    // Backpressure: in_valid held through RUN and DONE must not cause extra accepts.
    @(posedge clk); #1;
    bus4.in_a = 128'd10; bus4.in_b = 128'd20; bus4.in_sub = 0; bus4.in_cin = 0;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    chk("t4_ready_idle", bus4.in_ready, 1);
    for (int i = 0; i < NW; i++) begin
      @(posedge clk); #1;
      bus4.in_a = 128'(999 + i);
      chk("t4_ready_run", bus4.in_ready, 0);
      chk("t4_valid_run", bus4.out_valid, 0);
    end
    @(posedge clk); #1;
    chk("t4_valid_done", bus4.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      bus4.in_valid = i[0];
      #1;
      chk("t4_ready_stall", bus4.in_ready, 0);
      chk("t4_valid_stall", bus4.out_valid, 1);
      chk("t4_sum_stall", bus4.out_sum, 128'd30);
      @(posedge clk); #1;
    end
    bus4.in_a = 128'd100; bus4.in_b = 128'd200; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    #1;
    chk("t4_ready_release", bus4.in_ready, 1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    chk("t4_valid_after_b2b", bus4.out_valid, 0);
    chk("t4_ready_after_b2b", bus4.in_ready, 0);
    n = 0;
    while (!bus4.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("t4_b2b_latency", n, NW);
    chk("t4_b2b_sum", bus4.out_sum, 128'd300);
    $display("t4 back-to-back: sum=%h latency=%0d", bus4.out_sum, n);
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t4_no_extra_op", bus4.out_valid, 0);

    // Asynchronous reset in the middle of RUN, with two words already rewritten.
    @(posedge clk); #1;
    bus4.in_a = all_f; bus4.in_b = 128'd0; bus4.in_sub = 0; bus4.in_cin = 0; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("t5_partial_sum", bus4.out_sum, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", bus4.out_valid, 0);
    chk("t5_rst_sum", bus4.out_sum, 128'd0);
    chk("t5_rst_ready", bus4.in_ready, 1);
    $display("t5 mid-run reset: valid=%0d sum=%h ready=%0d", bus4.out_valid, bus4.out_sum, bus4.in_ready);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op4(128'd3, 128'd4, 0, 0, 128'd7, 0, 0, "t5_after_reset");

    op1(32'h7FFF_FFFF, 32'd1, 0, 0, 32'h8000_0000, 0, 1, "t6_one_word_ovf");
    op1(32'd0, 32'd1, 1, 0, 32'hFFFF_FFFF, 0, 0, "t6_one_word_borrow");
    op1(32'hFFFF_FFFF, 32'd0, 0, 1, 32'd0, 1, 0, "t6_one_word_cin");

    repeat (3) @(posedge clk);
    #1;
    chk("end_q4_empty", q4.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
